// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock enable, h/v raster position, visible flag,
// active-low syncs, line/frame start pulses and frame-stable score digits.
// Latency: counters and all decodes update together on the pclk_en edge; no backpressure.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   score0_in, score1_in      score digits from the game core (asynchronous to the raster)
//   pclk_en                   one-clk pulse every DIV clocks; the raster advances on it
//   h_cnt, v_cnt              current pixel column / line
//   valid                     visible-area flag
//   hsync, vsync              active-low sync strobes
//   line_start, frame_start   one-clk pulses on the first cycle of a new line / frame
//   score0, score1            score digits re-timed to the frame boundary
//
// H_TOT and V_TOT must each be <= 1024 and DIV must be >= 2.
module vga_timing_gen #(
    parameter int DIV    = 4,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] score0_in,
    input  logic [3:0] score1_in,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [3:0] score0,
    output logic [3:0] score1
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]    V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]    HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0]    HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0]    VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic          valid_q, valid_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [3:0]    score0_q, score0_d;
    logic [3:0]    score1_q, score1_d;
    logic          h_wrap, v_wrap;

    assign pclk_en = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = pclk_en ? '0 : div_cnt_q + 1'b1;
        h_wrap    = pclk_en && (h_cnt_q == H_LAST);
        v_wrap    = h_wrap && (v_cnt_q == V_LAST);

        h_cnt_d = h_cnt_q;
        if (pclk_en) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        end

        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end

        // Decodes are taken from the next counter values so that, once
        // registered, they line up exactly with the h_cnt/v_cnt they describe.
        valid_d = (h_cnt_d < H_VIS_C) && (v_cnt_d < V_VIS_C);
        hsync_d = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
        vsync_d = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));

        // Pulses come only from a real wrap, so reset exit never fires them.
        // They last one clk because DIV >= 2 keeps the next cycle off pclk_en.
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;

        // Scores load on the wrap edge so they change together with frame_start.
        score0_d = v_wrap ? score0_in : score0_q;
        score1_d = v_wrap ? score1_in : score1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            valid_q       <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            score0_q      <= 4'd0;
            score1_q      <= 4'd0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            valid_q       <= valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign score0      = score0_q;
    assign score1      = score1_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width horizontal timing with a shortened vertical
// raster (V_TOT = 12 lines) so two whole frames fit in a short run.
// Vertical window: visible v 0..5, vsync low for v 8..9, frame = 3200*12 clocks.
module tb_vga_timing_gen;

    localparam int TB_V_VIS  = 6;
    localparam int TB_V_FP   = 2;
    localparam int TB_V_SYNC = 2;
    localparam int TB_V_BP   = 2;
    localparam int FRAME_CLKS = 3200 * 12;
    localparam int SEEK_LIMIT = 45000;

    logic       clk;
    logic       rst;
    logic [3:0] score0_in;
    logic [3:0] score1_in;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [3:0] score0;
    logic [3:0] score1;

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .DIV    (4),
        .H_VIS  (640),
        .H_FP   (16),
        .H_SYNC (96),
        .H_BP   (48),
        .V_VIS  (TB_V_VIS),
        .V_FP   (TB_V_FP),
        .V_SYNC (TB_V_SYNC),
        .V_BP   (TB_V_BP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score0_in   (score0_in),
        .score1_in   (score1_in),
        .pclk_en     (pclk_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .score0      (score0),
        .score1      (score1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   h;
        int   v;
        logic valid;
        logic hsync;
        logic vsync;
        logic ls;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance (sampling on negedge) until the raster sits at (h, v).
    task automatic seek(input int h, input int v);
        int n;
        n = 0;
        while (!(int'(h_cnt) == h && int'(v_cnt) == v) && n < SEEK_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= SEEK_LIMIT) begin
            checks++;
            errors++;
            $display("FAIL seek(%0d,%0d): timed out at (%0d,%0d)", h, v, h_cnt, v_cnt);
        end
    endtask

    // Advance until h_cnt changes (at most one pixel period).
    task automatic step_pixel();
        int   n;
        logic [9:0] h0;
        h0 = h_cnt;
        n  = 0;
        while (h_cnt == h0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL step_pixel: h_cnt stuck at %0d", h_cnt);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".h_cnt"},       int'(h_cnt), 0);
        check({tag, ".v_cnt"},       int'(v_cnt), 0);
        check({tag, ".valid"},       int'(valid), 1);
        check({tag, ".hsync"},       int'(hsync), 1);
        check({tag, ".vsync"},       int'(vsync), 1);
        check({tag, ".line_start"},  int'(line_start), 0);
        check({tag, ".frame_start"}, int'(frame_start), 0);
        check({tag, ".pclk_en"},     int'(pclk_en), 0);
        check({tag, ".score0"},      int'(score0), 0);
        check({tag, ".score1"},      int'(score1), 0);
    endtask

    // Called on the negedge where rst has just been dropped: that cycle is index 0.
    task automatic check_restart(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, ".pclk_en_idx"}, int'(pclk_en), (i == 3) ? 1 : 0);
            check({tag, ".h_hold"},      int'(h_cnt), 0);
            check({tag, ".ls_quiet"},    int'(line_start), 0);
            @(negedge clk);
        end
        check({tag, ".h_after_div"}, int'(h_cnt), 1);
        check({tag, ".v_after_div"}, int'(v_cnt), 0);
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, val_fall;
        logic prev_valid;
        int cycles, pv_cnt, vs_cnt, vs_bad, score_bad;
        logic changed_in;

        vecs[0]  = '{0,   1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{639, 1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{640, 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{655, 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{656, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{751, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{752, 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{799, 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{0,   2, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{639, 5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{0,   6, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{0,   8, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{700, 9, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{0,  10, 1'b0, 1'b1, 1'b1, 1'b1};

        rst       = 1'b1;
        score0_in = 4'd3;
        score1_in = 4'd7;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_init");
        rst = 1'b0;
        check_restart("start_init");

        // One line: hsync window and valid fall, ending on entry to (0,1).
        hs_cnt = 0; hs_first = -1; hs_last = -1; val_fall = -1;
        prev_valid = valid;
        cycles = 0;
        while (!(h_cnt == 10'd0 && v_cnt == 10'd1) && cycles < 3300) begin
            if (!hsync) begin
                if (hs_first < 0) hs_first = int'(h_cnt);
                hs_last = int'(h_cnt);
                hs_cnt++;
            end
            if (prev_valid && !valid && val_fall < 0) val_fall = int'(h_cnt);
            prev_valid = valid;
            @(negedge clk);
            cycles++;
        end
        check("line0.reached_next_line", int'(v_cnt), 1);
        check("line0.hsync_low_clks", hs_cnt, 384);
        check("line0.hsync_first_h", hs_first, 656);
        check("line0.hsync_last_h", hs_last, 751);
        check("line0.valid_fall_h", val_fall, 640);

        foreach (vecs[i]) begin
            seek(vecs[i].h, vecs[i].v);
            check($sformatf("vec%0d.valid", i), int'(valid), int'(vecs[i].valid));
            check($sformatf("vec%0d.hsync", i), int'(hsync), int'(vecs[i].hsync));
            check($sformatf("vec%0d.vsync", i), int'(vsync), int'(vecs[i].vsync));
            check($sformatf("vec%0d.line_start", i), int'(line_start), int'(vecs[i].ls));
            check($sformatf("vec%0d.frame_start", i), int'(frame_start), 0);
        end

        // Line wrap (799,10) -> (0,11).
        seek(799, 10);
        step_pixel();
        check("lwrap.h", int'(h_cnt), 0);
        check("lwrap.v", int'(v_cnt), 11);
        check("lwrap.line_start", int'(line_start), 1);
        check("lwrap.frame_start", int'(frame_start), 0);
        @(negedge clk);
        check("lwrap.line_start_one_clk", int'(line_start), 0);

        // Frame wrap (799,11) -> (0,0); scores still at reset value until here.
        seek(799, 11);
        check("fwrap.score0_before", int'(score0), 0);
        check("fwrap.score1_before", int'(score1), 0);
        step_pixel();
        check("fwrap.h", int'(h_cnt), 0);
        check("fwrap.v", int'(v_cnt), 0);
        check("fwrap.line_start", int'(line_start), 1);
        check("fwrap.frame_start", int'(frame_start), 1);
        check("fwrap.score0", int'(score0), 3);
        check("fwrap.score1", int'(score1), 7);
        check("fwrap.valid", int'(valid), 1);

        // One whole frame, frame_start to frame_start, with a score change at v=3.
        cycles = 0; pv_cnt = 0; vs_cnt = 0; vs_bad = 0; score_bad = 0;
        changed_in = 1'b0;
        do begin
            if (pclk_en && valid) pv_cnt++;
            if (!vsync) begin
                vs_cnt++;
                if (!(v_cnt == 10'd8 || v_cnt == 10'd9)) vs_bad++;
            end
            if (score0 != 4'd3 || score1 != 4'd7) score_bad++;
            if (!changed_in && v_cnt == 10'd3 && h_cnt == 10'd0) begin
                score0_in  = 4'd5;
                score1_in  = 4'd9;
                changed_in = 1'b1;
            end
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                check("fwrap.frame_start_one_clk", int'(frame_start), 0);
                check("fwrap.line_start_one_clk", int'(line_start), 0);
            end
        end while (!frame_start && cycles < FRAME_CLKS + 100);
        check("frame.clks", cycles, FRAME_CLKS);
        check("frame.valid_pixels", pv_cnt, 640 * TB_V_VIS);
        check("frame.vsync_low_clks", vs_cnt, 2 * 3200);
        check("frame.vsync_outside_window", vs_bad, 0);
        check("frame.score_changed_early", score_bad, 0);
        check("frame2.score0", int'(score0), 5);
        check("frame2.score1", int'(score1), 9);
        check("frame2.line_start", int'(line_start), 1);
        check("frame2.pos", int'(h_cnt) + int'(v_cnt), 0);

        // Reset mid-frame.
        seek(300, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(negedge clk);
        check_reset_vals("rst_mid_hold");
        rst = 1'b0;
        check_restart("start_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the VGA raster timing for the display path. It produces the pixel-clock enable, the `h_cnt`/`v_cnt` raster position, the `valid` visible-area flag and the active-low `hsync`/`vsync` strobes that the pixel generator consumes. It also re-times the two score digits so that they change only at a frame boundary, which prevents tearing in the rendered digits. It sits between the game core and the pixel generator, and drives the VGA connector sync pins directly.

## Interface
- `DIV`, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); must be ≥ 2
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch

Port list (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous reset, active-high
- `score0_in`  in  4  right-digit score from the game core, may change at any time
- `score1_in`  in  4  left-digit score from the game core
- `pclk_en`  out  1  one-`clk` pulse every `DIV` clocks; the raster advances on it
- `h_cnt`  out  10  current pixel column, 0..H_TOT-1 (H_TOT = 800)
- `v_cnt`  out  10  current line, 0..V_TOT-1 (V_TOT = 525)
- `valid`  out  1  high while h_cnt < H_VIS and v_cnt < V_VIS
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `line_start`  out  1  one-`clk` pulse when h_cnt becomes 0
- `frame_start`  out  1  one-`clk` pulse when (h_cnt, v_cnt) becomes (0, 0)
- `score0`  out  4  frame-stable copy of `score0_in`
- `score1`  out  4  frame-stable copy of `score1_in`

## Operation
- **Divider.** `div_cnt` counts 0..DIV-1 and wraps. `pclk_en` is combinational, high when `div_cnt == DIV-1`.
- **Horizontal counter.** On each `pclk_en`, `h_cnt` increments. At H_TOT-1 it wraps to 0.
- **Vertical counter.** `v_cnt` increments on a `pclk_en` where `h_cnt == H_TOT-1`. At V_TOT-1 it wraps to 0 in the same cycle that h wraps.
- **Registered decodes.** `valid`, `hsync`, `vsync`, `line_start` and `frame_start` are registered. Each is computed from the *next* counter values, so every one is exactly aligned with the `h_cnt`/`v_cnt` it describes, with no skew.
- **hsync.** Low for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. [656, 751].
- **vsync.** Low for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. [490, 491]. It is independent of h_cnt.
- **line_start.** High for one `clk` in the first cycle where h_cnt = 0 after a wrap. It is not asserted on reset exit.
- **frame_start.** High for one `clk` in the first cycle where (h_cnt, v_cnt) = (0, 0) after a wrap. It is not asserted on reset exit.
- **Score latch.** `score0`/`score1` load `score0_in`/`score1_in` on the same edge that the counters wrap to (0, 0). That makes them valid together with `frame_start`. At all other times they hold.
- **Counter width.** H_TOT and V_TOT must each be ≤ 1024. The counters never exceed TOT-1.

## Timing
Reset values (while `rst` is high and in the first cycle after it):

| Output | Value |
|---|---|
| `div_cnt` | 0 |
| `h_cnt` | 0 |
| `v_cnt` | 0 |
| `valid` | 1 |
| `hsync` | 1 |
| `vsync` | 1 |
| `line_start` | 0 |
| `frame_start` | 0 |
| `score0`, `score1` | 0 |

Cycle-level behaviour:
- **First enable.** The first `pclk_en` occurs DIV-1 clocks after `rst` is deasserted, i.e. at clock index 3 for DIV = 4.
- **Counter latency.** `h_cnt` changes on the `clk` edge where `pclk_en` = 1. The new value is visible the cycle after `pclk_en`.
- **Period lengths.** Each pixel value is held for DIV clocks. One line is H_TOT·DIV = 3200 clocks. One frame is 3200·525 = 1,680,000 clocks.
- **Decoded outputs.** The registered decodes change on the same edge as the counters, with zero relative latency.
- **Reset mid-frame.** Reset forces everything to the reset values on the next edge. There is no pulse on `line_start` or `frame_start`, and the scores clear to 0. The raster restarts at (0, 0) with `div_cnt` = 0.
- **Simultaneous wrap.** When h and v wrap together, `line_start` and `frame_start` are both high in the same cycle.
- **Score changes.** A change on `score*_in` during a frame is not visible on `score*` until the next `frame_start`. A change coincident with the wrap edge is captured.

## Test plan
- **Reset.** Assert `rst` mid-frame at (h 300, v 200). Required: next cycle h_cnt = 0, v_cnt = 0, valid = 1, hsync = 1, vsync = 1, score0 = 0, frame_start = 0. The first `pclk_en` arrives 3 clocks after release.
- **hsync window.** Run one line. Required: hsync is low for exactly 96 pixels (384 clks), starting when h_cnt = 656 and ending after h_cnt = 751. valid falls when h_cnt = 640.
- **Line wrap.** At (799, 10), the next pixel is (0, 11). `line_start` is high for one `clk` and `frame_start` stays 0.
- **Frame wrap.** At (799, 524), the next pixel is (0, 0). `line_start` and `frame_start` are both high for one `clk`. vsync was low exactly for v = 490 and 491, i.e. 6400 clks.
- **Score latch.** Set score0_in = 5 at v = 100. Required: score0 stays at its old value until (0, 0) of the next frame, then becomes 5 together with `frame_start`.
- **Frame length.** Count `clk` cycles between two `frame_start` pulses. Required: exactly 1,680,000, with exactly 307,200 cycles having `valid` and `pclk_en` both high.
